// File: rtl/oric_bus_mux.sv
// oric_bus_mux: CPU read-data multiplexer for an Oric-style system.
// Picks the highest-priority active read source into a registered CPU_DI.
// Holds the last value when nothing drives the bus, emulating a floating bus.
// Also owns the write-lockable ROM bank register and a saturating count of
// cycles in which more than one source was driving the bus.
module oric_bus_mux #(
  parameter int          NUM_ROMS  = 4,
  parameter int          NUM_EXP   = 2,
  parameter logic [15:0] BANK_ADDR = 16'h03FB,
  localparam int         BW        = $clog2(NUM_ROMS)
) (
  input  logic                  CLK_IN,
  input  logic                  RESET,
  input  logic                  PHI2,
  input  logic                  PHI2_EN,
  input  logic                  CPU_RW,
  input  logic [15:0]           CPU_AD,
  input  logic [7:0]            CPU_DO,
  input  logic                  CSIO_N,
  input  logic                  CSROM_N,
  input  logic                  CSRAM_N,
  input  logic                  LATCH_SRAM,
  input  logic                  MAP_N,
  input  logic                  ROMDIS_N,
  input  logic                  MD_ECE_N,
  input  logic [NUM_EXP-1:0]    EXP_SEL,
  input  logic [8*NUM_EXP-1:0]  EXP_DO,
  input  logic [7:0]            VIA_DO,
  input  logic [7:0]            MD_ROM_DO,
  input  logic [7:0]            SRAM_DO,
  input  logic [8*NUM_ROMS-1:0] ROM_DO,
  input  logic [BW-1:0]         ROM_SEL_DEFAULT,
  output logic [7:0]            CPU_DI,
  output logic [BW-1:0]         ROM_BANK,
  output logic                  BANK_LOCKED,
  output logic [7:0]            CONFLICT_CNT
);

  logic [7:0]         cpu_di_q, cpu_di_d;
  logic [BW-1:0]      rom_bank_q, rom_bank_d;
  logic               bank_locked_q, bank_locked_d;
  logic [7:0]         conflict_cnt_q, conflict_cnt_d;

  logic [NUM_EXP-1:0] exp_act;
  logic               via_act, rom_act, md_act, sram_act, any_act;
  logic [7:0]         exp_data, rom_data, src_data;
  logic [3:0]         n_act;
  logic               read_cyc, bank_wr;
  logic [BW-1:0]      wr_bank, rst_bank;
  logic               unused_cpu_do;

  // Only the low bank-select bits and the lock bit of a write are meaningful.
  assign unused_cpu_do = ^CPU_DO[6:BW];

  // Decode which sources drive the bus and count them for conflict detection
  always_comb begin
    exp_act  = EXP_SEL & {NUM_EXP{~CSIO_N}};
    via_act  = ~CSIO_N & ~(|EXP_SEL);
    rom_act  = CSIO_N & ~CSROM_N & MAP_N & ROMDIS_N;
    md_act   = ~MD_ECE_N & ~ROMDIS_N & MAP_N;
    sram_act = ~CSRAM_N & ~LATCH_SRAM;
    any_act  = (|exp_act) | via_act | rom_act | md_act | sram_act;
    n_act    = 4'd0;
    for (int i = 0; i < NUM_EXP; i++) begin
      n_act = n_act + {3'b000, exp_act[i]};
    end
    n_act = n_act + {3'b000, via_act} + {3'b000, rom_act}
                  + {3'b000, md_act} + {3'b000, sram_act};
  end

  // Select read data; lowest-numbered expansion source wins among expansions
  always_comb begin
    exp_data = 8'h00;
    for (int i = NUM_EXP - 1; i >= 0; i--) begin
      if (exp_act[i]) exp_data = EXP_DO[8*i +: 8];
    end
    rom_data = 8'h00;
    for (int i = 0; i < NUM_ROMS; i++) begin
      if (rom_bank_q == BW'(i)) rom_data = ROM_DO[8*i +: 8];
    end
    if (|exp_act)      src_data = exp_data;
    else if (via_act)  src_data = VIA_DO;
    else if (rom_act)  src_data = rom_data;
    else if (md_act)   src_data = MD_ROM_DO;
    else               src_data = SRAM_DO;
  end

  // Next-state: data capture, conflict counter and bank register
  always_comb begin
    read_cyc = CPU_RW & PHI2;
    cpu_di_d = (read_cyc & any_act) ? src_data : cpu_di_q;

    conflict_cnt_d = conflict_cnt_q;
    if (PHI2_EN & read_cyc & (n_act >= 4'd2) & (conflict_cnt_q != 8'hFF))
      conflict_cnt_d = conflict_cnt_q + 8'd1;

    // A bank write never claims read data; VIA reads at BANK_ADDR still work.
    bank_wr = PHI2_EN & PHI2 & ~CPU_RW & ~CSIO_N & (CPU_AD == BANK_ADDR)
            & ~bank_locked_q;
    wr_bank       = CPU_DO[BW-1:0];
    rom_bank_d    = rom_bank_q;
    bank_locked_d = bank_locked_q;
    if (bank_wr) begin
      if (int'(wr_bank) < NUM_ROMS) rom_bank_d = wr_bank;
      if (CPU_DO[7])                bank_locked_d = 1'b1;
    end

    // Out-of-range default bank falls back to bank 0.
    rst_bank = (int'(ROM_SEL_DEFAULT) < NUM_ROMS) ? ROM_SEL_DEFAULT : '0;
  end

  // Register update; reset overrides any capture or write on the same edge
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      cpu_di_q       <= 8'hFF;
      rom_bank_q     <= rst_bank;
      bank_locked_q  <= 1'b0;
      conflict_cnt_q <= 8'h00;
    end else begin
      cpu_di_q       <= cpu_di_d;
      rom_bank_q     <= rom_bank_d;
      bank_locked_q  <= bank_locked_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign CPU_DI       = cpu_di_q;
  assign ROM_BANK     = rom_bank_q;
  assign BANK_LOCKED  = bank_locked_q;
  assign CONFLICT_CNT = conflict_cnt_q;

endmodule

// File: tb/tb_oric_bus_mux.sv
// Testbench for oric_bus_mux: vector table, directed sequences, random run
// against a queue-based reference model. A second instance with three ROM
// banks exercises default clamping and out-of-range bank writes.
module tb_oric_bus_mux;

  logic        clk;
  logic        rst;
  logic        phi2, phi2_en, rw;
  logic [15:0] cpu_ad;
  logic [7:0]  cpu_do;
  logic        csio_n, csrom_n, csram_n, latch, map_n, romdis_n, md_ece_n;
  logic [1:0]  exp_sel;
  logic [15:0] exp_do;
  logic [7:0]  via_do, md_do, sram_do;
  logic [31:0] rom_do;

  logic [7:0]  di, di3, cnt, cnt3;
  logic [1:0]  bank, bank3;
  logic        lock, lock3;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state, index 0 = four-bank DUT, 1 = three-bank DUT
  logic [7:0] m_di   [2];
  int         m_bank [2];
  int         m_lock [2];
  int         m_cnt  [2];
  int         nr     [2] = '{4, 3};
  int         def    [2] = '{2, 3};

  oric_bus_mux #(.NUM_ROMS(4), .NUM_EXP(2), .BANK_ADDR(16'h03FB)) dut (
    .CLK_IN(clk), .RESET(rst), .PHI2(phi2), .PHI2_EN(phi2_en), .CPU_RW(rw),
    .CPU_AD(cpu_ad), .CPU_DO(cpu_do), .CSIO_N(csio_n), .CSROM_N(csrom_n),
    .CSRAM_N(csram_n), .LATCH_SRAM(latch), .MAP_N(map_n), .ROMDIS_N(romdis_n),
    .MD_ECE_N(md_ece_n), .EXP_SEL(exp_sel), .EXP_DO(exp_do), .VIA_DO(via_do),
    .MD_ROM_DO(md_do), .SRAM_DO(sram_do), .ROM_DO(rom_do),
    .ROM_SEL_DEFAULT(2'd2), .CPU_DI(di), .ROM_BANK(bank),
    .BANK_LOCKED(lock), .CONFLICT_CNT(cnt)
  );

  oric_bus_mux #(.NUM_ROMS(3), .NUM_EXP(2), .BANK_ADDR(16'h03FB)) dut3 (
    .CLK_IN(clk), .RESET(rst), .PHI2(phi2), .PHI2_EN(phi2_en), .CPU_RW(rw),
    .CPU_AD(cpu_ad), .CPU_DO(cpu_do), .CSIO_N(csio_n), .CSROM_N(csrom_n),
    .CSRAM_N(csram_n), .LATCH_SRAM(latch), .MAP_N(map_n), .ROMDIS_N(romdis_n),
    .MD_ECE_N(md_ece_n), .EXP_SEL(exp_sel), .EXP_DO(exp_do), .VIA_DO(via_do),
    .MD_ROM_DO(md_do), .SRAM_DO(sram_do), .ROM_DO(rom_do[23:0]),
    .ROM_SEL_DEFAULT(2'd3), .CPU_DI(di3), .ROM_BANK(bank3),
    .BANK_LOCKED(lock3), .CONFLICT_CNT(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Active sources in priority order; first entry is what the CPU reads.
  function automatic void eval(input int b, output int n, output logic [7:0] first);
    logic [7:0] q[$];
    for (int i = 0; i < 2; i++)
      if (!csio_n && exp_sel[i]) q.push_back(exp_do[8*i +: 8]);
    if (!csio_n && exp_sel == 2'b00)                 q.push_back(via_do);
    if (csio_n && !csrom_n && map_n && romdis_n)     q.push_back(rom_do[8*b +: 8]);
    if (!md_ece_n && !romdis_n && map_n)             q.push_back(md_do);
    if (!csram_n && !latch)                          q.push_back(sram_do);
    n = q.size();
    first = (n > 0) ? q[0] : 8'h00;
  endfunction

  task automatic model_step();
    int n;
    logic [7:0] f;
    int v;
    for (int k = 0; k < 2; k++) begin
      eval(m_bank[k], n, f);
      if (rst) begin
        m_di[k]   = 8'hFF;
        m_bank[k] = (def[k] < nr[k]) ? def[k] : 0;
        m_lock[k] = 0;
        m_cnt[k]  = 0;
      end else begin
        if (rw && phi2 && n > 0) m_di[k] = f;
        if (phi2_en && rw && phi2 && n >= 2 && m_cnt[k] < 255) m_cnt[k]++;
        if (phi2_en && phi2 && !rw && !csio_n && cpu_ad == 16'h03FB && m_lock[k] == 0) begin
          v = cpu_do % 4;
          if (v < nr[k]) m_bank[k] = v;
          if (cpu_do[7]) m_lock[k] = 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    chk("rnd_di",    di,    m_di[0]);
    chk("rnd_bank",  bank,  m_bank[0]);
    chk("rnd_lock",  lock,  m_lock[0]);
    chk("rnd_cnt",   cnt,   m_cnt[0]);
    chk("rnd_di3",   di3,   m_di[1]);
    chk("rnd_bank3", bank3, m_bank[1]);
    chk("rnd_lock3", lock3, m_lock[1]);
    chk("rnd_cnt3",  cnt3,  m_cnt[1]);
  endtask

  task automatic set_idle();
    rw = 1'b1; phi2 = 1'b0; phi2_en = 1'b0;
    csio_n = 1'b1; csrom_n = 1'b1; csram_n = 1'b1; latch = 1'b0;
    map_n = 1'b1; romdis_n = 1'b1; md_ece_n = 1'b1; exp_sel = 2'b00;
  endtask

  task automatic set_conflict();
    set_idle();
    phi2 = 1'b1; csio_n = 1'b0; exp_sel = 2'b11;
  endtask

  task automatic set_rom_read();
    set_idle();
    phi2 = 1'b1; csrom_n = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    set_idle();
    rw = 1'b0; phi2 = 1'b1; phi2_en = 1'b1; csio_n = 1'b0;
    cpu_ad = a; cpu_do = d;
    tick();
    set_idle();
  endtask

  typedef struct {
    logic [8:0] dec;   // rw phi2 csio_n csrom_n csram_n latch map_n romdis_n md_ece_n
    logic [1:0] es;
    logic [7:0] exp;
  } vec_t;

  vec_t tv[16];

  initial begin
    tv[0]  = '{9'b1_1_1_0_1_0_1_1_1, 2'b00, 8'hA9};  // ROM bank 2
    tv[1]  = '{9'b1_1_0_1_1_0_1_1_1, 2'b11, 8'h3C};  // both EXP, lowest wins
    tv[2]  = '{9'b1_1_0_1_1_0_1_1_1, 2'b10, 8'h5A};  // EXP1
    tv[3]  = '{9'b1_1_0_1_1_0_1_1_1, 2'b00, 8'h11};  // VIA
    tv[4]  = '{9'b1_1_1_1_1_0_1_0_0, 2'b00, 8'h22};  // microdisc ROM
    tv[5]  = '{9'b1_1_1_1_0_0_1_1_1, 2'b00, 8'h42};  // SRAM
    tv[6]  = '{9'b1_1_0_1_1_0_1_1_1, 2'b00, 8'h11};  // VIA again
    tv[7]  = '{9'b1_1_1_1_1_0_1_1_1, 2'b00, 8'h11};  // nothing: hold
    tv[8]  = '{9'b1_0_1_0_1_0_1_1_1, 2'b00, 8'h11};  // PHI2 low: hold
    tv[9]  = '{9'b0_1_1_0_1_0_1_1_1, 2'b00, 8'h11};  // write cycle: hold
    tv[10] = '{9'b1_1_1_1_0_1_1_1_1, 2'b00, 8'h11};  // SRAM latched: hold
    tv[11] = '{9'b1_1_1_0_0_0_1_1_1, 2'b00, 8'hA9};  // ROM beats SRAM
    tv[12] = '{9'b1_1_0_1_0_0_1_1_1, 2'b01, 8'h3C};  // EXP0 beats SRAM
    tv[13] = '{9'b1_1_1_1_0_0_1_1_1, 2'b00, 8'h42};  // SRAM
    tv[14] = '{9'b1_1_1_0_1_0_0_0_0, 2'b00, 8'h42};  // MAP_N low: ROM and MD off
    tv[15] = '{9'b1_1_1_1_0_0_1_0_0, 2'b00, 8'h22};  // MD beats SRAM

    for (int k = 0; k < 2; k++) begin
      m_di[k] = 8'h00; m_bank[k] = 0; m_lock[k] = 0; m_cnt[k] = 0;
    end
    set_idle();
    cpu_ad = 16'h0000; cpu_do = 8'h00;
    exp_do = 16'h5A3C; via_do = 8'h11; md_do = 8'h22; sram_do = 8'h42;
    rom_do = {8'hD3, 8'hA9, 8'hC1, 8'hB0};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_di",    di,    8'hFF);
    chk("rst_bank",  bank,  2'd2);
    chk("rst_lock",  lock,  1'b0);
    chk("rst_cnt",   cnt,   8'h00);
    chk("rst_bank3", bank3, 2'd0);
    rst = 1'b0;

    // Read-source priority table
    for (int i = 0; i < 16; i++) begin
      {rw, phi2, csio_n, csrom_n, csram_n, latch, map_n, romdis_n, md_ece_n} = tv[i].dec;
      exp_sel = tv[i].es;
      tick();
      chk($sformatf("vec%0d_di", i), di, tv[i].exp);
    end
    chk("vec_cnt_no_en", cnt, 8'h00);

    // Conflict counted only at PHI2_EN
    set_conflict(); phi2_en = 1'b1;
    tick();
    chk("conf_di",  di,  8'h3C);
    chk("conf_cnt", cnt, 8'h01);
    phi2_en = 1'b0;
    tick();
    chk("conf_cnt_hold", cnt, 8'h01);

    // Bank writes; new bank is not visible before the write edge
    set_idle();
    rw = 1'b0; phi2 = 1'b1; phi2_en = 1'b1; csio_n = 1'b0;
    cpu_ad = 16'h03FB; cpu_do = 8'h01;
    #1;
    chk("bank_pre_edge", bank, 2'd2);
    tick();
    set_idle();
    chk("wr01_bank",  bank,  2'd1);
    chk("wr01_bank3", bank3, 2'd1);
    set_rom_read();
    tick();
    chk("rom_bank1_di", di, 8'hC1);
    bus_write(16'h03FB, 8'h05);
    chk("wr05_bank",  bank, 2'd1);
    bus_write(16'h03FA, 8'h02);
    chk("wr_badaddr", bank, 2'd1);
    bus_write(16'h03FB, 8'h03);
    chk("wr03_bank",  bank,  2'd3);
    chk("wr03_bank3", bank3, 2'd1);
    bus_write(16'h03FB, 8'h02);
    chk("wr02_bank3", bank3, 2'd2);
    bus_write(16'h03FB, 8'h83);
    chk("wr83_bank",  bank,  2'd3);
    chk("wr83_lock",  lock,  1'b1);
    chk("wr83_bank3", bank3, 2'd2);
    chk("wr83_lock3", lock3, 1'b1);
    bus_write(16'h03FB, 8'h00);
    chk("locked_bank", bank, 2'd3);
    set_rom_read();
    tick();
    chk("rom_bank3_di", di, 8'hD3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("unlock_bank",  bank,  2'd2);
    chk("unlock_lock",  lock,  1'b0);
    chk("unlock_bank3", bank3, 2'd0);
    chk("unlock_cnt",   cnt,   8'h00);

    // Saturation of the conflict counter
    set_conflict(); phi2_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 99) chk("sat_cnt_100", cnt, 8'd100);
    end
    chk("sat_cnt", cnt, 8'hFF);

    // Floating bus hold and reset in the middle of a read
    set_idle(); phi2 = 1'b1; csram_n = 1'b0; sram_do = 8'h42;
    tick();
    chk("sram_di", di, 8'h42);
    csram_n = 1'b1;
    tick();
    chk("float_di", di, 8'h42);
    csram_n = 1'b0; sram_do = 8'h77; rst = 1'b1;
    tick();
    chk("midrst_di", di, 8'hFF);
    rst = 1'b0;
    tick();
    chk("resume_di", di, 8'h77);

    // Randomised run against the reference model
    for (int c = 0; c < 1500; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      rw       = 1'($urandom_range(0, 1));
      phi2     = ($urandom_range(0, 3) != 0);
      phi2_en  = 1'($urandom_range(0, 1));
      {csio_n, csrom_n, csram_n, latch, map_n, romdis_n, md_ece_n} = 7'($urandom);
      exp_sel  = 2'($urandom);
      cpu_ad   = ($urandom_range(0, 3) == 0) ? 16'h03FB : 16'($urandom);
      cpu_do   = 8'($urandom) & (($urandom_range(0, 15) == 0) ? 8'hFF : 8'h7F);
      exp_do   = 16'($urandom);
      via_do   = 8'($urandom);
      md_do    = 8'($urandom);
      sram_do  = 8'($urandom);
      rom_do   = $urandom;
      tick();
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
